// File: rtl/cordic_mult_seq_if.sv
// Host-side request/response bundle for the sequential CORDIC multiplier.
interface cordic_mult_seq_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
);
  logic                    start;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] result;
  logic [CNT_W-1:0]        count_div;
  logic                    ovf;

  modport master (output start, x_in, z_in,
                  input  busy, done, result, count_div, ovf);
  modport slave  (input  start, x_in, z_in,
                  output busy, done, result, count_div, ovf);
endinterface

// File: rtl/cordic_mult_seq.sv
// Sequential fixed-point multiplier: normalise z by halving, run ITER
// linear-CORDIC micro-rotations on one add/shift datapath, rescale by 2^k.
module cordic_mult_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ITER  = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  cordic_mult_seq_if.slave bus
);
  localparam int YW = WIDTH + 2;          // accumulator: no internal wrap
  localparam int PW = YW + (1 << CNT_W);  // y <<< k at full width
  localparam int IW = $clog2(ITER + 1);

  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(64'd1 << FRAC);
  localparam logic signed [WIDTH-1:0] TWO  = WIDTH'(64'd1 << (FRAC + 1));
  localparam logic signed [WIDTH-1:0] NTWO = -TWO;
  localparam logic signed [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_SCALE} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, z_q, z_d, res_q, res_d;
  logic signed [YW-1:0]    y_q, y_d;
  logic [CNT_W-1:0]        k_q, k_d, cnt_q, cnt_d;
  logic [IW-1:0]           i_q, i_d;
  logic                    ovf_q, ovf_d, done_q, done_d, busy_q, busy_d;

  logic                    in_range, last_iter, fits;
  logic signed [YW-1:0]    x_ext, x_sh;
  logic signed [WIDTH-1:0] one_sh;
  logic signed [PW-1:0]    p_full;

  assign in_range  = (z_q > NTWO) && (z_q < TWO);
  assign last_iter = (i_q == IW'(ITER - 1));
  assign x_ext     = YW'(x_q);
  assign x_sh      = x_ext >>> i_q;
  assign one_sh    = ONE >>> i_q;
  assign p_full    = PW'(y_q) <<< k_q;
  // p fits in WIDTH signed when every bit above the result's sign bit matches it
  assign fits      = (p_full[PW-1:WIDTH-1] == '0) || (p_full[PW-1:WIDTH-1] == '1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_NORM;
      S_NORM:  if (in_range)  state_d = S_ITER;
      S_ITER:  if (last_iter) state_d = S_SCALE;
      S_SCALE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath and output next values; done defaults low so it pulses
  always_comb begin
    x_d    = x_q;
    z_d    = z_q;
    y_d    = y_q;
    k_d    = k_q;
    i_d    = i_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d    = bus.x_in;
          z_d    = bus.z_in;
          y_d    = '0;
          k_d    = '0;
          i_d    = '0;
          busy_d = 1'b1;
        end
      end
      S_NORM: begin
        if (!in_range) begin
          z_d = z_q >>> 1;
          k_d = k_q + CNT_W'(1);
        end
      end
      S_ITER: begin
        if (!z_q[WIDTH-1]) begin
          y_d = y_q + x_sh;
          z_d = z_q - one_sh;
        end else begin
          y_d = y_q - x_sh;
          z_d = z_q + one_sh;
        end
        i_d = i_q + IW'(1);
      end
      S_SCALE: begin
        if (fits) begin
          res_d = p_full[WIDTH-1:0];
          ovf_d = 1'b0;
        end else begin
          res_d = y_q[YW-1] ? MINN : MAXP;
          ovf_d = 1'b1;
        end
        cnt_d  = k_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      z_q    <= '0;
      y_q    <= '0;
      k_q    <= '0;
      i_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      z_q    <= z_d;
      y_q    <= y_d;
      k_q    <= k_d;
      i_q    <= i_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.count_div = cnt_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cordic_mult_seq.sv
// Directed + randomized bench for cordic_mult_seq against a real-valued model.
module tb_cordic_mult_seq;
  localparam int    ITER = 16;
  localparam longint TWO = 64'sd131072;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  cordic_mult_seq_if #(.WIDTH(32), .CNT_W(5)) bus ();
  cordic_mult_seq #(.WIDTH(32), .FRAC(16), .ITER(ITER), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_tol(input string tag, input longint obs, input real ref_v, input real tol);
    real d;
    n_chk++;
    d = real'(obs) - ref_v;
    if (d < 0.0) d = -d;
    assert (d <= tol) n_pass++;
    else $error("FAIL %s: got %0d expected %f (+/- %f)", tag, obs, ref_v, tol);
  endtask

  // halve z until strictly inside (-2.0, +2.0)
  function automatic void norm(input longint z, output int k, output longint zn);
    zn = z;
    k  = 0;
    while (!(zn > -TWO && zn < TWO)) begin
      zn = zn >>> 1;
      k++;
    end
  endfunction

  task automatic launch(input longint x, input longint z);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = x[31:0];
    bus.z_in  = z[31:0];
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_job(input string tag, input longint x, input longint z,
                           input int lat, input bit got);
    int     k;
    longint zn;
    real    prod, tol, ax;
    bit     eovf;
    norm(z, k, zn);
    chk({tag, "_done"}, longint'(got), 1);
    chk({tag, "_lat"}, longint'(lat), longint'(k + ITER + 2));
    chk({tag, "_cnt"}, longint'(bus.count_div), longint'(k));
    prod = real'(x) * real'(z) / 65536.0;
    eovf = (prod > 2147483647.0) || (prod < -2147483648.0);
    chk({tag, "_ovf"}, longint'(bus.ovf), longint'(eovf));
    if (eovf)
      chk({tag, "_sat"}, longint'($signed(bus.result)),
          (prod > 0.0) ? 64'sd2147483647 : -64'sd2147483648);
    else begin
      ax  = (x < 0) ? -real'(x) : real'(x);
      tol = ax * (2.0 ** (k - ITER + 1)) + (2.0 ** k);
      chk_tol({tag, "_res"}, longint'($signed(bus.result)), prod, tol);
    end
  endtask

  task automatic job(input string tag, input longint x, input longint z);
    int lat;
    bit got;
    launch(x, z);
    wait_done(lat, got);
    check_job(tag, x, z, lat, got);
  endtask

  initial begin
    int     lat, lat2, k, seen;
    bit     got;
    longint x, z, zn, prev;

    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.z_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_res",  longint'($signed(bus.result)), 0);
    chk("rst_cnt",  longint'(bus.count_div), 0);
    chk("rst_ovf",  longint'(bus.ovf), 0);
    rst = 1'b0;

    job("mul_3x1p5",  196608, 98304);
    job("mul_2x5",    131072, 327680);
    job("neg_m2",     -65536, -131072);
    job("zero_x",     0, 327680);
    launch(65536, 131071);
    wait_done(lat, got);
    chk("z_edge_done", longint'(got), 1);
    chk("z_edge_cnt", longint'(bus.count_div), 0);
    job("ovf_pos",  1073741824, 262144);
    job("ovf_neg", -1073741824, 262144);

    // start pulses while busy must be ignored
    prev = longint'($signed(bus.result));
    launch(196608, 98304);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ign_busy", longint'(bus.busy), 1);
      chk("ign_hold", longint'($signed(bus.result)), prev);
      bus.start = 1'b1;
      bus.x_in  = 32'sd655360;
      bus.z_in  = 32'sd655360;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    wait_done(lat2, got);
    check_job("ign_job", 196608, 98304, lat2 + 6, got);

    // start raised in the done cycle is accepted
    bus.start = 1'b1;
    bus.x_in  = 32'sd131072;
    bus.z_in  = 32'sd327680;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("dc_busy", longint'(bus.busy), 1);
    chk("dc_done", longint'(bus.done), 0);
    wait_done(lat, got);
    check_job("dc_job", 131072, 327680, lat, got);

    // randomized jobs; x on a 0.5 grid and z on a 64-LSB grid keep all shifts exact
    for (int r = 0; r < 24; r++) begin
      do begin
        x = (longint'($urandom_range(0, 64)) - 32) * 32768;
        z = (longint'($urandom_range(0, 131072)) - 65536) * 64;
        norm(z, k, zn);
      end while (zn > 131070 || zn < -131070);
      job($sformatf("rnd%0d", r), x, z);
    end

    // reset in the 5th ITER cycle aborts the job
    launch(65536, 65536);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", longint'(bus.busy), 0);
    chk("mid_done", longint'(bus.done), 0);
    chk("mid_res",  longint'($signed(bus.result)), 0);
    chk("mid_cnt",  longint'(bus.count_div), 0);
    chk("mid_ovf",  longint'(bus.ovf), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("mid_nodone", longint'(seen), 0);
    job("post_rst", -131072, 327680);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
